// File: rtl/mmul_result_streamer.sv
// Result streamer for a matrix multiplier: on a rising edge of the multiplier's
// completed flag the whole result matrix C is snapshotted, then emitted one
// element per transfer in row-major order over a valid/ready handshake.
// All outputs come from registers, so out_ready never reaches out_valid
// combinationally.

module mmul_result_streamer #(
    parameter int RA = 2,
    parameter int CB = 2,
    parameter int W  = 32,
    localparam int RW = (RA > 1) ? $clog2(RA) : 1,
    localparam int CW = (CB > 1) ? $clog2(CB) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [RA*CB*W-1:0] C_in,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    out_row,
    output logic [CW-1:0]    out_col,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int N = RA * CB;

    typedef enum logic [1:0] {StIdle, StCapture, StStream, StDone} state_e;

    state_e           state;
    logic             start_q;
    logic             rise;
    logic [N*W-1:0]   buf_q;

    logic [RW-1:0]    nxt_row;
    logic [CW-1:0]    nxt_col;
    logic [31:0]      nxt_idx;
    logic [W-1:0]     nxt_data;
    logic             nxt_last;
    logic             xfer;

    // Edge detect on start and the element that follows the current one.
    always_comb begin
        rise    = start & ~start_q;
        xfer    = out_valid & out_ready;
        nxt_row = out_row;
        nxt_col = out_col + 1'b1;
        if (out_col == CW'(CB - 1)) begin
            nxt_col = '0;
            nxt_row = out_row + 1'b1;
        end
        nxt_idx  = 32'(nxt_row) * 32'(CB) + 32'(nxt_col);
        nxt_last = (nxt_row == RW'(RA - 1)) && (nxt_col == CW'(CB - 1));
        // Past the last element the index is out of range; never loaded then.
        nxt_data = (nxt_idx < 32'(N)) ? buf_q[nxt_idx*W +: W] : '0;
    end

    // Snapshot of C taken on the triggering edge; contents are don't-care otherwise.
    always_ff @(posedge clk) begin
        if (state == StIdle && rise) begin
            buf_q <= C_in;
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            start_q   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            start_q <= start;
            unique case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (rise) begin
                        state <= StCapture;
                        busy  <= 1'b1;
                    end
                end
                StCapture: begin
                    state     <= StStream;
                    out_row   <= '0;
                    out_col   <= '0;
                    out_data  <= buf_q[W-1:0];
                    out_last  <= (N == 1);
                    out_valid <= 1'b1;
                end
                StStream: begin
                    if (xfer) begin
                        if (out_last) begin
                            state     <= StDone;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_row  <= nxt_row;
                            out_col  <= nxt_col;
                            out_data <= nxt_data;
                            out_last <= nxt_last;
                        end
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mmul_result_streamer.sv
// Directed bench for mmul_result_streamer: a 2x2 instance covers the main
// stream, backpressure, start-level handling, late C changes and reset; a
// 3x1 instance covers the single-column shape.

module tb_mmul_result_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // 2x2, W=8 instance
    logic        rst_n;
    logic        start;
    logic [31:0] c_in;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [0:0]  out_row;
    logic [0:0]  out_col;
    logic        out_last;
    logic        busy;
    logic        done;

    mmul_result_streamer #(.RA(2), .CB(2), .W(8)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .C_in      (c_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // 3x1, W=8 instance
    logic        rst_nb;
    logic        startb;
    logic [23:0] c_inb;
    logic [7:0]  out_datab;
    logic        out_validb;
    logic        out_readyb;
    logic [1:0]  out_rowb;
    logic [0:0]  out_colb;
    logic        out_lastb;
    logic        busyb;
    logic        doneb;

    mmul_result_streamer #(.RA(3), .CB(1), .W(8)) dut_b (
        .clk       (clk),
        .rst_n     (rst_nb),
        .start     (startb),
        .C_in      (c_inb),
        .out_data  (out_datab),
        .out_valid (out_validb),
        .out_ready (out_readyb),
        .out_row   (out_rowb),
        .out_col   (out_colb),
        .out_last  (out_lastb),
        .busy      (busyb),
        .done      (doneb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_a [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [0:0] exp_r [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [0:0] exp_c [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       rdy_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int idx;
        int cnt;

        rst_n = 1'b1; rst_nb = 1'b1;
        start = 1'b0; startb = 1'b0;
        out_ready = 1'b0; out_readyb = 1'b0;
        c_in = 32'h04030201; c_inb = 24'h332211;
        #2;
        rst_n = 1'b0; rst_nb = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_data",  32'(out_data), 32'd0);
        chk("rst_rowcol", {30'd0, out_row, out_col}, 32'd0);
        chk("rst_last",  32'(out_last), 32'd0);
        tick();
        tick();
        rst_n = 1'b1; rst_nb = 1'b1;
        tick();

        // Frame 1: ready held high, one element per cycle.
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        chk("cap_busy",  32'(busy), 32'd1);
        chk("cap_valid", 32'(out_valid), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("f1_valid", 32'(out_valid), 32'd1);
            chk("f1_data",  32'(out_data), 32'(exp_a[k]));
            chk("f1_row",   32'(out_row), 32'(exp_r[k]));
            chk("f1_col",   32'(out_col), 32'(exp_c[k]));
            chk("f1_last",  32'(out_last), (k == 3) ? 32'd1 : 32'd0);
            tick();
        end
        chk("f1_done",       32'(done), 32'd1);
        chk("f1_done_valid", 32'(out_valid), 32'd0);
        chk("f1_done_busy",  32'(busy), 32'd0);
        tick();
        chk("f1_done_pulse", 32'(done), 32'd0);

        // Start held high: no retrigger.
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid || busy) cnt++;
            tick();
        end
        chk("held_start_idle", 32'(cnt), 32'd0);

        // Frame 2: backpressure pattern and C change after capture.
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        c_in = 32'hFFFFFFFF;
        tick();
        idx = 0;
        cnt = 0;
        for (int k = 0; k < 7; k++) begin
            out_ready = rdy_pat[k];
            chk("f2_valid", 32'(out_valid), 32'd1);
            chk("f2_data",  32'(out_data), 32'(exp_a[idx]));
            chk("f2_rowcol", {30'd0, out_row, out_col}, {30'd0, exp_r[idx], exp_c[idx]});
            if (out_valid && out_ready) cnt++;
            tick();
            if (rdy_pat[k]) idx++;
        end
        chk("f2_xfers", 32'(cnt), 32'd4);
        chk("f2_done",  32'(done), 32'd1);

        // Frame 3: reset after the second transfer.
        out_ready = 1'b1;
        c_in = 32'h04030201;
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("f3_third", 32'(out_data), 32'h03);
        rst_n = 1'b0;
        #1;
        chk("f3_rst_valid", 32'(out_valid), 32'd0);
        chk("f3_rst_busy",  32'(busy), 32'd0);
        start = 1'b0;
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid || busy) cnt++;
        end
        chk("f3_quiet", 32'(cnt), 32'd0);

        // Start already high at reset release counts as a rise.
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_busy", 32'(busy), 32'd1);
        tick();
        chk("rel_data", 32'(out_data), 32'h01);
        tick(); tick(); tick(); tick();
        chk("rel_done", 32'(done), 32'd1);
        start = 1'b0;

        // 3x1 instance.
        out_readyb = 1'b1;
        startb = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("b_valid", 32'(out_validb), 32'd1);
            chk("b_data",  32'(out_datab), 32'h11 * (k + 1));
            chk("b_row",   32'(out_rowb), 32'(k));
            chk("b_col",   32'(out_colb), 32'd0);
            chk("b_last",  32'(out_lastb), (k == 2) ? 32'd1 : 32'd0);
            tick();
        end
        chk("b_done", 32'(doneb), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
